// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: SRAM geometry, digest width, loader FSM states and
// the byte-index to word-address helper.
package sha1_pkg;
    localparam int DIGEST_W = 160;
    localparam int SRAM_AW  = 16;
    localparam int SRAM_DW  = 32;

    typedef enum logic [1:0] {FILL, COMMIT, START, WAIT} loader_state_e;

    typedef struct packed {
        logic               we;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] data;
    } sram_wr_t;

    // Byte address of the word holding byte idx.
    function automatic logic [SRAM_AW-1:0] word_addr(input logic [SRAM_AW-1:0] base,
                                                     input logic [SRAM_AW-1:0] idx);
        return base + (idx & ~SRAM_AW'(3));
    endfunction
endpackage

// File: rtl/sha1_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words and issues one SRAM
// write per completed (or final partial) word, one cycle after the byte lands.
module sha1_byte_packer
    import sha1_pkg::*;
#(
    parameter logic [SRAM_AW-1:0] BASE_ADDR = 16'h0000,
    parameter int                 MAX_BYTES = 4096,
    localparam int                CNT_W     = $clog2(MAX_BYTES) + 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             accept,
    input  logic [7:0]       byte_data,
    input  logic             last,
    input  logic             clear,
    output sram_wr_t         wr,
    output logic [CNT_W-1:0] count,
    output logic             eom,
    output logic             overflow
);
    logic [1:0]         lane;
    logic [SRAM_DW-1:0] word_q, word_nxt;

    assign lane     = count[1:0];
    assign overflow = accept && !last && (count == CNT_W'(MAX_BYTES - 1));
    assign eom      = accept && (last || overflow);

    // Lane 0 starts a fresh word so unfilled lanes of a short tail read as 0.
    always_comb begin
        word_nxt = (lane == 2'd0) ? '0 : word_q;
        word_nxt[{lane, 3'b000} +: 8] = byte_data;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            word_q <= '0;
            count  <= '0;
            wr     <= '{we: 1'b0, addr: BASE_ADDR, data: '0};
        end else begin
            wr.we <= 1'b0;
            if (clear) count <= '0;
            if (accept) begin
                word_q <= word_nxt;
                count  <= count + CNT_W'(1);
                if (lane == 2'd3 || eom) begin
                    wr.we   <= 1'b1;
                    wr.addr <= word_addr(BASE_ADDR, SRAM_AW'(count));
                    wr.data <= word_nxt;
                end
            end
        end
    end
endmodule

// File: rtl/sha1_msg_loader.sv
// Loads a byte-stream message into SRAM port A, kicks the SHA-1 hasher and
// captures its digest on a fresh low-to-high completion.
module sha1_msg_loader
    import sha1_pkg::*;
#(
    parameter logic [SRAM_AW-1:0] BASE_ADDR = 16'h0000,
    parameter int                 MAX_BYTES = 4096
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                port_A_clk,
    output logic [SRAM_AW-1:0]  port_A_addr,
    output logic [SRAM_DW-1:0]  port_A_data_in,
    input  logic [SRAM_DW-1:0]  port_A_data_out,
    output logic                port_A_we,
    output logic                start_hash,
    output logic [31:0]         message_addr,
    output logic [31:0]         message_size,
    input  logic                hash_done,
    input  logic [DIGEST_W-1:0] hash_in,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                err
);
    localparam int CNT_W = $clog2(MAX_BYTES) + 1;

    loader_state_e    state_q, state_d;
    logic             accept, eom, overflow, seen_low, done_hit;
    logic [CNT_W-1:0] count;
    sram_wr_t         wr;
    logic             unused_rdata;

    assign in_ready     = (state_q == FILL);
    assign accept       = in_valid && in_ready;
    // hash_done may still be high from the previous message; require a low first.
    assign done_hit     = (state_q == WAIT) && seen_low && hash_done;

    assign port_A_clk     = clk;
    assign port_A_we      = wr.we;
    assign port_A_addr    = wr.addr;
    assign port_A_data_in = wr.data;
    assign message_addr   = {16'h0000, BASE_ADDR};
    assign unused_rdata   = ^port_A_data_out;

    sha1_byte_packer #(
        .BASE_ADDR (BASE_ADDR),
        .MAX_BYTES (MAX_BYTES)
    ) u_packer (
        .clk       (clk),
        .nreset    (nreset),
        .accept    (accept),
        .byte_data (in_data),
        .last      (in_last),
        .clear     (state_q == COMMIT),
        .wr        (wr),
        .count     (count),
        .eom       (eom),
        .overflow  (overflow)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (eom) state_d = COMMIT;
            COMMIT:  state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (done_hit) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= FILL;
            start_hash   <= 1'b0;
            message_size <= '0;
            seen_low     <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_hash   <= (state_q == COMMIT);
            digest_valid <= done_hit;
            if (state_q == COMMIT) message_size <= 32'(count);
            if (state_q == START) seen_low <= 1'b0;
            else if (state_q == WAIT && !hash_done) seen_low <= 1'b1;
            if (done_hit) digest <= hash_in;
            if (overflow) err <= 1'b1;
            else if (accept && count == '0) err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sha1_msg_loader.sv
// Directed bench for sha1_msg_loader: a message-level model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_sha1_msg_loader;
    localparam logic [15:0] BASE = 16'h0100;
    localparam int          MAXB = 8;
    localparam logic [159:0] D_ABC = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] D_2   = 160'h0123456789abcdef0011223344556677deadbeef;
    localparam logic [159:0] D_3   = 160'hfedcba98765432100f1e2d3c4b5a6978cafef00d;
    localparam logic [159:0] D_4   = 160'h1111222233334444555566667777888899990000;

    logic         clk = 1'b0, nreset = 1'b1;
    logic         in_valid = 1'b0, in_last = 1'b0, hash_done = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic [159:0] hash_in = '0;
    logic         in_ready, port_A_clk, port_A_we, start_hash, digest_valid, err;
    logic [15:0]  port_A_addr;
    logic [31:0]  port_A_data_in, message_addr, message_size;
    logic [31:0]  port_A_data_out = 32'h0;
    logic [159:0] digest;

    sha1_msg_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB)) dut (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .port_A_clk(port_A_clk),
        .port_A_addr(port_A_addr), .port_A_data_in(port_A_data_in),
        .port_A_data_out(port_A_data_out), .port_A_we(port_A_we),
        .start_hash(start_hash), .message_addr(message_addr),
        .message_size(message_size), .hash_done(hash_done), .hash_in(hash_in),
        .digest(digest), .digest_valid(digest_valid), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    function automatic void chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- message-level model ----------------
    logic [7:0]   m_msg[$];
    bit           m_busy = 0, m_seen_low = 0;
    int           cyc = 0, m_last_p = -100;
    logic         e_ready = 1, e_we = 0, e_start = 0, e_dv = 0, e_err = 0;
    logic [15:0]  e_addr = BASE;
    logic [31:0]  e_data = 0, e_size = 0;
    logic [159:0] e_dig = 0;

    function automatic logic [31:0] word_of(input int w);
        logic [31:0] d = '0;
        for (int j = 0; j < 4; j++)
            if (4*w + j < m_msg.size()) d[8*j +: 8] = m_msg[4*w + j];
        return d;
    endfunction

    always @(posedge clk or negedge nreset) begin : model
        int k;
        bit eom;
        if (!nreset) begin
            m_msg.delete(); m_busy = 0; m_seen_low = 0; m_last_p = -100;
            e_ready = 1; e_we = 0; e_addr = BASE; e_data = 0; e_start = 0;
            e_size = 0; e_dv = 0; e_dig = 0; e_err = 0;
        end else begin
            cyc = cyc + 1;
            e_we = 0; e_start = 0; e_dv = 0;
            if (e_ready && in_valid) begin
                k   = m_msg.size();
                eom = in_last || (k == MAXB - 1);
                m_msg.push_back(in_data);
                if (!in_last && k == MAXB - 1) e_err = 1;
                else if (k == 0) e_err = 0;
                if (k % 4 == 3 || eom) begin
                    e_we = 1; e_addr = BASE + 16'(4 * (k / 4)); e_data = word_of(k / 4);
                end
                if (eom) begin m_busy = 1; m_last_p = cyc; e_ready = 0; end
            end
            if (m_busy && cyc == m_last_p + 1) begin e_start = 1; e_size = 32'(m_msg.size()); end
            if (m_busy && cyc >= m_last_p + 3) begin
                if (hash_done && m_seen_low) begin
                    e_dv = 1; e_dig = hash_in; m_busy = 0; m_seen_low = 0;
                    m_msg.delete(); e_ready = 1;
                end else if (!hash_done) m_seen_low = 1;
            end
        end
    end

    // ---------------- per-cycle compare + logs for literal checks ----------------
    logic [15:0] wl_a[$];
    logic [31:0] wl_d[$];
    int st_n = 0, st_edge = 0, dv_n = 0;

    always @(negedge clk) begin
        chk("in_ready", 160'(in_ready), 160'(e_ready));
        chk("we", 160'(port_A_we), 160'(e_we));
        chk("addr", 160'(port_A_addr), 160'(e_addr));
        chk("wdata", 160'(port_A_data_in), 160'(e_data));
        chk("start_hash", 160'(start_hash), 160'(e_start));
        chk("message_size", 160'(message_size), 160'(e_size));
        chk("message_addr", 160'(message_addr), 160'({16'h0, BASE}));
        chk("digest_valid", 160'(digest_valid), 160'(e_dv));
        chk("digest", digest, e_dig);
        chk("err", 160'(err), 160'(e_err));
        if (port_A_we) begin wl_a.push_back(port_A_addr); wl_d.push_back(port_A_data_in); end
        // cyc+1 is the edge that samples start_hash high
        if (start_hash) begin st_n++; st_edge = cyc + 1; end
        if (digest_valid) dv_n++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input int n, input logic [7:0] first, input bit last, input bit toggle);
        for (int i = 0; i < n; i++) begin
            in_valid = 1; in_data = first + 8'(i); in_last = last && (i == n - 1);
            tick();
            if (toggle) begin in_valid = 0; in_last = 0; tick(); end
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic finish_hash(input logic [159:0] d);
        hash_done = 0; repeat (3) tick();
        hash_in = d; hash_done = 1; repeat (3) tick();
    endtask

    task automatic chk_writes(input int n, input logic [15:0] a0, input logic [31:0] d0,
                              input logic [15:0] a1, input logic [31:0] d1);
        chk("n_writes", 160'(wl_a.size()), 160'(n));
        if (n >= 1 && wl_a.size() >= 1) begin
            chk("w0_addr", 160'(wl_a[0]), 160'(a0)); chk("w0_data", 160'(wl_d[0]), 160'(d0));
        end
        if (n >= 2 && wl_a.size() >= 2) begin
            chk("w1_addr", 160'(wl_a[1]), 160'(a1)); chk("w1_data", 160'(wl_d[1]), 160'(d1));
        end
        wl_a.delete(); wl_d.delete();
    endtask

    initial begin
        #1 nreset = 0;
        repeat (3) tick();
        chk("rst_in_ready", 160'(in_ready), 160'(1));
        chk("rst_addr", 160'(port_A_addr), 160'(BASE));
        nreset = 1;
        tick();

        // "abc"
        dv_n = 0; st_n = 0;
        send(3, 8'h61, 1, 0);
        finish_hash(D_ABC);
        chk_writes(1, 16'h0100, 32'h00636261, 16'h0, 32'h0);
        chk("abc_size", 160'(message_size), 160'(3));
        chk("abc_start_gap", 160'(st_edge - m_last_p), 160'(2));
        chk("abc_digest", digest, D_ABC);
        chk("abc_dv_n", 160'(dv_n), 160'(1));

        // 00..07 with hash_done still high from the previous run
        dv_n = 0;
        send(8, 8'h00, 1, 0);
        repeat (10) tick();
        chk("sticky_no_dv", 160'(dv_n), 160'(0));
        chk("sticky_busy", 160'(in_ready), 160'(0));
        finish_hash(D_2);
        chk_writes(2, 16'h0100, 32'h03020100, 16'h0104, 32'h07060504);
        chk("eight_size", 160'(message_size), 160'(8));
        chk("sticky_dv_n", 160'(dv_n), 160'(1));

        // same bytes with gapped in_valid
        send(8, 8'h00, 1, 1);
        finish_hash(D_3);
        chk_writes(2, 16'h0100, 32'h03020100, 16'h0104, 32'h07060504);
        chk("gap_size", 160'(message_size), 160'(8));

        // overflow: 10 bytes offered, no in_last
        send(10, 8'h40, 0, 0);
        chk("ovf_err", 160'(err), 160'(1));
        chk("ovf_ready", 160'(in_ready), 160'(0));
        finish_hash(D_4);
        chk_writes(2, 16'h0100, 32'h43424140, 16'h0104, 32'h47464544);
        chk("ovf_size", 160'(message_size), 160'(8));
        chk("ovf_err_sticky", 160'(err), 160'(1));

        // reset after 5 bytes
        send(5, 8'h20, 0, 0);
        chk_writes(1, 16'h0100, 32'h23222120, 16'h0, 32'h0);
        st_n = 0;
        nreset = 0;
        repeat (3) tick();
        chk("mid_rst_size", 160'(message_size), 160'(0));
        chk("mid_rst_digest", digest, 160'(0));
        nreset = 1;
        repeat (6) tick();
        chk_writes(0, 16'h0, 32'h0, 16'h0, 32'h0);
        chk("mid_rst_no_start", 160'(st_n), 160'(0));

        // "abc" again behaves as the first time
        dv_n = 0;
        send(3, 8'h61, 1, 0);
        finish_hash(D_ABC);
        chk_writes(1, 16'h0100, 32'h00636261, 16'h0, 32'h0);
        chk("abc2_size", 160'(message_size), 160'(3));
        chk("abc2_start_gap", 160'(st_edge - m_last_p), 160'(2));
        chk("abc2_digest", digest, D_ABC);
        chk("abc2_dv_n", 160'(dv_n), 160'(1));

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
